// File: rtl/mac_pkg.sv
// Types and widths shared by the MAC controller and its datapath.
package mac_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ACC_W = 12;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    LDAB      = 4'd2,
    MUL       = 4'd3,
    ACC       = 4'd4,
    CNT       = 4'd5,
    CHK       = 4'd6,
    OUT       = 4'd7,
    WAIT_DONE = 4'd8,
    FIN       = 4'd9
  } state_t;

endpackage

// File: rtl/mac_timeout_cnt.sv
// Loadable up-counter; last flags the final cycle before LIMIT is reached.
module mac_timeout_cnt #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (inc)     cnt <= cnt + 1'b1;
  end

  assign last = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mac_controller.sv
// Sequencing FSM for the MAC datapath: operand fetch, per-term strobes, completion wait.
module mac_controller
  import mac_pkg::*;
#(
  parameter int unsigned N_TERMS      = 10,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [OP_W-1:0] in_a,
  input  logic [OP_W-1:0] in_b,
  output logic            in_ready,
  input  logic            cmp,
  input  logic            dp_done,
  output logic [OP_W-1:0] A,
  output logic [OP_W-1:0] B,
  output logic            load_a,
  output logic            load_b,
  output logic            load_m,
  output logic            load_acc,
  output logic            load_out,
  output logic            count_enable,
  output logic            busy,
  output logic            finished,
  output logic            err_timeout,
  output logic            mismatch
);

  state_t           state, nxt;
  logic [CNT_W-1:0] iter;
  logic             last_term;
  logic             to_last;
  logic             to_clear;
  logic             to_inc;

  assign last_term = (iter == CNT_W'(N_TERMS - 1));
  assign to_clear  = (state == OUT);
  assign to_inc    = (state == WAIT_DONE) && !dp_done;

  mac_timeout_cnt #(
    .LIMIT (DONE_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (to_clear),
    .inc   (to_inc),
    .last  (to_last)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (start) nxt = FETCH;
      FETCH:     if (in_valid) nxt = LDAB;
      LDAB:      nxt = MUL;
      MUL:       nxt = ACC;
      ACC:       nxt = CNT;
      CNT:       nxt = CHK;
      CHK:       nxt = last_term ? OUT : FETCH;
      OUT:       nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (dp_done)      nxt = FIN;
        else if (to_last) nxt = IDLE;
      end
      FIN:       nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      iter         <= '0;
      A            <= '0;
      B            <= '0;
      in_ready     <= 1'b0;
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      load_m       <= 1'b0;
      load_acc     <= 1'b0;
      load_out     <= 1'b0;
      count_enable <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      err_timeout  <= 1'b0;
      mismatch     <= 1'b0;
    end else begin
      state        <= nxt;
      in_ready     <= (nxt == FETCH);
      load_a       <= (nxt == LDAB);
      load_b       <= (nxt == LDAB);
      load_m       <= (nxt == MUL);
      load_acc     <= (nxt == ACC);
      count_enable <= (nxt == CNT);
      load_out     <= (nxt == OUT);
      busy         <= (nxt != IDLE);
      finished     <= (nxt == FIN);

      if (state == IDLE && start) begin
        iter        <= '0;
        err_timeout <= 1'b0;
        mismatch    <= 1'b0;
      end
      if (state == FETCH && in_valid) begin
        A <= in_a;
        B <= in_b;
      end
      if (state == CHK && !last_term) begin
        iter <= iter + 1'b1;
        if (cmp) mismatch <= 1'b1;
      end
      if (state == WAIT_DONE && !dp_done && to_last) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_controller.sv
// Directed bench for mac_controller with a small MAC datapath model.
module tb_mac_controller;
  import mac_pkg::*;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, cmp, dp_done;
  logic [OP_W-1:0] in_a, in_b, A, B;
  logic            in_ready, load_a, load_b, load_m, load_acc, load_out, count_enable;
  logic            busy, finished, err_timeout, mismatch;

  int unsigned passes = 0;
  int unsigned checks = 0;

  int unsigned n_la = 0, n_lb = 0, n_lm = 0, n_acc = 0, n_ce = 0, n_out = 0, n_fin = 0;
  int unsigned b_la, b_lb, b_lm, b_acc, b_ce, b_out, b_fin;

  logic [ACC_W-1:0] prod = '0, acc = '0, dp_out = '0;

  mac_controller #(
    .N_TERMS      (10),
    .CNT_W        (4),
    .DONE_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_ready     (in_ready),
    .cmp          (cmp),
    .dp_done      (dp_done),
    .A            (A),
    .B            (B),
    .load_a       (load_a),
    .load_b       (load_b),
    .load_m       (load_m),
    .load_acc     (load_acc),
    .load_out     (load_out),
    .count_enable (count_enable),
    .busy         (busy),
    .finished     (finished),
    .err_timeout  (err_timeout),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  // Strobe counters and datapath model, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_a)       n_la  <= n_la + 1;
    if (load_b)       n_lb  <= n_lb + 1;
    if (load_m)       n_lm  <= n_lm + 1;
    if (load_acc)     n_acc <= n_acc + 1;
    if (count_enable) n_ce  <= n_ce + 1;
    if (load_out)     n_out <= n_out + 1;
    if (finished)     n_fin <= n_fin + 1;
    if (load_m)       prod  <= ACC_W'(A) * ACC_W'(B);
    if (!busy)        acc   <= '0;
    else if (load_acc) acc  <= acc + prod;
    if (load_out)     dp_out <= acc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic snap();
    b_la = n_la; b_lb = n_lb; b_lm = n_lm; b_acc = n_acc;
    b_ce = n_ce; b_out = n_out; b_fin = n_fin;
  endtask

  task automatic chk_counts(input string tag, input int unsigned terms, input int unsigned fins);
    chk({tag, "_load_a"},   n_la  - b_la,  terms);
    chk({tag, "_load_b"},   n_lb  - b_lb,  terms);
    chk({tag, "_load_m"},   n_lm  - b_lm,  terms);
    chk({tag, "_load_acc"}, n_acc - b_acc, terms);
    chk({tag, "_cnt_en"},   n_ce  - b_ce,  terms);
    chk({tag, "_load_out"}, n_out - b_out, 1);
    chk({tag, "_finished"}, n_fin - b_fin, fins);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outs"}, {in_ready, load_a, load_b, load_m, load_acc, load_out,
                         count_enable, busy, finished, err_timeout, mismatch}, 0);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_iter"}, dut.iter, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; cmp = 1'b0; dp_done = 1'b0;
    in_a = 4'd0; in_b = 4'd0;
    tick(2);
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    // Nominal run: FIN lands 6*N+2 edges after the start edge.
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd2; dp_done = 1'b1;
    snap();
    go();
    chk("nom_fetch", in_ready, 1);
    tick();
    chk("nom_first_load_a", load_a, 1);
    chk("nom_A", A, 3);
    chk("nom_B", B, 2);
    tick(61);
    chk("nom_finished", finished, 1);
    tick();
    chk("nom_idle", busy, 0);
    chk_counts("nom", 10, 1);
    chk("nom_out", dp_out, 60);

    // Backpressure on term 5.
    snap();
    go();
    tick(24);
    in_valid = 1'b0; in_a = 4'd7; in_b = 4'd7;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", in_ready, 1);
      chk("bp_strobes", {load_a, load_m, load_acc, count_enable}, 0);
      chk("bp_A", A, 3);
      tick();
    end
    chk("bp_ready5", in_ready, 1);
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd2;
    tick();
    chk("bp_resume", load_a, 1);
    tick(37);
    chk("bp_finished", finished, 1);
    tick();
    chk_counts("bp", 10, 1);
    chk("bp_out", dp_out, 60);

    // Timeout: dp_done never arrives.
    dp_done = 1'b0;
    snap();
    go();
    tick(60);
    chk("to_load_out", load_out, 1);
    tick(15);
    chk("to_wait_busy", busy, 1);
    chk("to_wait_err", err_timeout, 0);
    tick();
    chk("to_idle", busy, 0);
    chk("to_err", err_timeout, 1);
    chk("to_nofin", finished, 0);
    tick();
    chk("to_err_sticky", err_timeout, 1);
    chk_counts("to", 10, 0);
    go();
    chk("to_err_cleared", err_timeout, 0);

    // Reset mid-run in ACC of term 3.
    tick(15);
    chk("rmid_acc", load_acc, 1);
    rst = 1'b1;
    tick();
    chk_quiet("rmid");
    rst = 1'b0;
    tick();

    // Early cmp in CHK of term 4.
    dp_done = 1'b1;
    snap();
    go();
    tick(23);
    chk("cmp_pre", mismatch, 0);
    cmp = 1'b1;
    tick();
    cmp = 1'b0;
    chk("cmp_set", mismatch, 1);
    tick(38);
    chk("cmp_finished", finished, 1);
    chk("cmp_sticky", mismatch, 1);
    tick();
    chk_counts("cmp", 10, 1);
    chk("cmp_out", dp_out, 60);

    // Ignored inputs: start/dp_done/in_a mid-term, cmp on final term.
    dp_done = 1'b0;
    snap();
    go();
    tick(2);
    chk("ign_mul", load_m, 1);
    dp_done = 1'b1; start = 1'b1; in_a = 4'd9;
    tick();
    chk("ign_acc", load_acc, 1);
    chk("ign_A", A, 3);
    chk("ign_nofin", finished, 0);
    dp_done = 1'b0; start = 1'b0; in_a = 4'd3;
    tick(56);
    cmp = 1'b1;
    tick();
    cmp = 1'b0;
    chk("ign_load_out", load_out, 1);
    chk("ign_final_cmp", mismatch, 0);
    dp_done = 1'b1;
    tick(2);
    chk("ign_finished", finished, 1);
    tick();
    chk_counts("ign", 10, 1);
    chk("ign_out", dp_out, 60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
